// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter client-2 requester: widths, command record, FSM states.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    typedef struct packed {
        logic                  rd_not_write;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        REQ       = 2'd2,
        RSP       = 2'd3
    } state_t;

endpackage

// File: rtl/c2_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module c2_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ram_c2_requester.sv
// Client-2 master for the RAM arbiter: queues commands, runs one REQUEST_C2/ACK_C2
// transaction per command with a timeout, and returns one response per command.
module ram_c2_requester
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = RAM_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLOCK,
    input  logic              RST_N,
    input  logic              RST_DONE,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_RD_NOT_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_IS_READ,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              REQUEST_C2,
    output logic              RD_NOT_WRITE_C2,
    output logic [ADDR_W-1:0] ADDR_C2,
    output logic [DATA_W-1:0] DATAIN_C2,
    input  logic [DATA_W-1:0] DATAOUT_C2,
    input  logic              ACK_C2,
    output logic              BUSY
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic [CMD_W-1:0]  head;
    logic              head_rd;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign push = CMD_VALID & CMD_READY & ~fifo_full;
    assign pop  = (state == IDLE) & RST_DONE & ~fifo_empty;
    assign {head_rd, head_addr, head_wdata} = head;

    c2_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLOCK),
        .rst_n     (RST_N),
        .push      (push),
        .push_data ({CMD_RD_NOT_WRITE, CMD_ADDR, CMD_WDATA}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // CMD_READY is registered, so it is derived from the occupancy after this edge.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + CNT_ONE;
        else if (pop && !push) count_next = fifo_count - CNT_ONE;
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_N) begin
            state           <= WAIT_INIT;
            timer           <= '0;
            CMD_READY       <= 1'b0;
            REQUEST_C2      <= 1'b0;
            RD_NOT_WRITE_C2 <= 1'b0;
            ADDR_C2         <= '0;
            DATAIN_C2       <= '0;
            RSP_VALID       <= 1'b0;
            RSP_IS_READ     <= 1'b0;
            RSP_RDATA       <= '0;
            RSP_ERROR       <= 1'b0;
        end else begin
            CMD_READY <= (count_next != CNT_FULL);
            case (state)
                WAIT_INIT: begin
                    if (RST_DONE) state <= IDLE;
                end
                IDLE: begin
                    if (!RST_DONE) begin
                        state <= WAIT_INIT;
                    end else if (!fifo_empty) begin
                        REQUEST_C2      <= 1'b1;
                        RD_NOT_WRITE_C2 <= head_rd;
                        ADDR_C2         <= head_addr;
                        DATAIN_C2       <= head_rd ? '0 : head_wdata;
                        timer           <= '0;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    // ACK is checked first so a grant on the timeout edge still completes.
                    if (ACK_C2) begin
                        REQUEST_C2  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_IS_READ <= RD_NOT_WRITE_C2;
                        RSP_RDATA   <= RD_NOT_WRITE_C2 ? DATAOUT_C2 : '0;
                        RSP_ERROR   <= 1'b0;
                        state       <= RSP;
                    end else if (timer == TMR_LAST) begin
                        REQUEST_C2  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_IS_READ <= RD_NOT_WRITE_C2;
                        RSP_RDATA   <= '0;
                        RSP_ERROR   <= 1'b1;
                        state       <= RSP;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                RSP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= WAIT_INIT;
            endcase
        end
    end

    assign BUSY = ~fifo_empty | (state == REQ) | (state == RSP);

endmodule

// File: tb/tb_ram_c2_requester.sv
// Directed bench for ram_c2_requester: vector table plus hand-written multi-cycle sequences.
module tb_ram_c2_requester;
    import ram_arb_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RST_N, RST_DONE;
    logic       CMD_VALID, CMD_READY, CMD_RD_NOT_WRITE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_WDATA;
    logic       RSP_VALID, RSP_READY, RSP_IS_READ, RSP_ERROR;
    logic [7:0] RSP_RDATA;
    logic       REQUEST_C2, RD_NOT_WRITE_C2, ACK_C2, BUSY;
    logic [3:0] ADDR_C2;
    logic [7:0] DATAIN_C2, DATAOUT_C2;

    int n_vec = 0;
    int n_err = 0;

    int         ack_delay;
    logic [7:0] ack_data;
    int         req_cnt;

    cmd_t issued_q[$];
    cmd_t rise_cmd;
    logic prev_req, stable_bad, seen_req;
    int   hi_cnt, lo_cnt, last_hi_len;

    typedef struct {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] dout;
        logic       exp_is_read;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_hi;
    } vec_t;
    vec_t vecs[6];
    cmd_t exp_order[5];

    always #5 CLOCK = ~CLOCK;

    ram_c2_requester dut (
        .CLOCK(CLOCK), .RST_N(RST_N), .RST_DONE(RST_DONE),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RD_NOT_WRITE(CMD_RD_NOT_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_IS_READ(RSP_IS_READ),
        .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
        .REQUEST_C2(REQUEST_C2), .RD_NOT_WRITE_C2(RD_NOT_WRITE_C2), .ADDR_C2(ADDR_C2),
        .DATAIN_C2(DATAIN_C2), .DATAOUT_C2(DATAOUT_C2), .ACK_C2(ACK_C2), .BUSY(BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_cmd(input logic rd, input logic [3:0] a, input logic [7:0] d);
        int t = 0;
        CMD_VALID = 1'b1; CMD_RD_NOT_WRITE = rd; CMD_ADDR = a; CMD_WDATA = d;
        while (!CMD_READY && t < 200) begin tick(); t++; end
        chk("cmd_accept", CMD_READY, 1);
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_req(input int lim);
        int t = 0;
        while (!REQUEST_C2 && t < lim) begin tick(); t++; end
        chk("req_seen", REQUEST_C2, 1);
    endtask

    task automatic wait_rsp(input int lim);
        int t = 0;
        while (!RSP_VALID && t < lim) begin tick(); t++; end
        chk("rsp_seen", RSP_VALID, 1);
    endtask

    task automatic consume();
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        chk("rsp_cleared", RSP_VALID, 0);
    endtask

    // Arbiter model: raises ACK_C2 once REQUEST_C2 has been seen ack_delay times (-1 = never).
    initial begin
        ACK_C2 = 1'b0; DATAOUT_C2 = '0; req_cnt = 0;
        forever begin
            tick();
            if (REQUEST_C2 && !ACK_C2) begin
                req_cnt++;
                if (ack_delay >= 0 && req_cnt == ack_delay) begin
                    ACK_C2 = 1'b1; DATAOUT_C2 = ack_data;
                end
            end else begin
                ACK_C2 = 1'b0; DATAOUT_C2 = '0; req_cnt = 0;
            end
        end
    end

    // Request monitor: issue order, field stability, high length, low gap between requests.
    initial begin
        prev_req = 1'b0; stable_bad = 1'b0; seen_req = 1'b0;
        hi_cnt = 0; lo_cnt = 0; last_hi_len = 0;
        forever begin
            tick();
            if (REQUEST_C2) begin
                if (!prev_req) begin
                    if (seen_req) chk("req_gap_ge2", (lo_cnt >= 2), 1);
                    seen_req = 1'b1;
                    rise_cmd = '{rd_not_write: RD_NOT_WRITE_C2, addr: ADDR_C2, wdata: DATAIN_C2};
                    issued_q.push_back(rise_cmd);
                    stable_bad = 1'b0;
                    hi_cnt = 0;
                end else if ({RD_NOT_WRITE_C2, ADDR_C2, DATAIN_C2} != rise_cmd) begin
                    stable_bad = 1'b1;
                end
                hi_cnt++;
            end else begin
                if (prev_req) begin
                    last_hi_len = hi_cnt;
                    chk("req_fields_stable", stable_bad, 0);
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            prev_req = REQUEST_C2;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int   t;

        //            rd    addr   wdata  dly  dout   isrd  rdata  err  hi
        vecs[0] = '{1'b1, 4'h6, 8'h00,  2, 8'h9D, 1'b1, 8'h9D, 1'b0,  2};
        vecs[1] = '{1'b0, 4'h4, 8'h5C,  1, 8'hFF, 1'b0, 8'h00, 1'b0,  1};
        vecs[2] = '{1'b1, 4'h3, 8'h00, -1, 8'h77, 1'b1, 8'h00, 1'b1, 64};
        vecs[3] = '{1'b0, 4'h7, 8'h81,  5, 8'h11, 1'b0, 8'h00, 1'b0,  5};
        vecs[4] = '{1'b1, 4'hF, 8'h00, 64, 8'h3C, 1'b1, 8'h3C, 1'b0, 64};
        vecs[5] = '{1'b1, 4'h0, 8'h00, 63, 8'hC3, 1'b1, 8'hC3, 1'b0, 63};

        exp_order[0] = '{rd_not_write: 1'b0, addr: 4'hA, wdata: 8'hA1};
        exp_order[1] = '{rd_not_write: 1'b1, addr: 4'hA, wdata: 8'h00};
        exp_order[2] = '{rd_not_write: 1'b0, addr: 4'h1, wdata: 8'h23};
        exp_order[3] = '{rd_not_write: 1'b1, addr: 4'h1, wdata: 8'h00};
        exp_order[4] = '{rd_not_write: 1'b1, addr: 4'hF, wdata: 8'h00};

        RST_N = 1'b0; RST_DONE = 1'b0; CMD_VALID = 1'b0; CMD_RD_NOT_WRITE = 1'b0;
        CMD_ADDR = '0; CMD_WDATA = '0; RSP_READY = 1'b0;
        ack_delay = 3; ack_data = 8'hAA;

        // Reset and init gating
        tick(); tick();
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_request", REQUEST_C2, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_addr", ADDR_C2, 0);
        chk("rst_rdata", RSP_RDATA, 0);
        RST_N = 1'b1;
        tick();
        chk("ready_after_rst", CMD_READY, 1);
        push_cmd(1'b0, 4'hE, 8'hE3);
        chk("busy_queued", BUSY, 1);
        bad = 1'b0;
        repeat (6) begin tick(); if (REQUEST_C2) bad = 1'b1; end
        chk("no_req_before_init", bad, 0);
        RST_DONE = 1'b1;
        tick();
        chk("req_idle_edge", REQUEST_C2, 0);
        tick();
        chk("req_after_init", REQUEST_C2, 1);
        chk("init_addr", ADDR_C2, 4'hE);
        chk("init_datain", DATAIN_C2, 8'hE3);
        chk("init_rnw", RD_NOT_WRITE_C2, 0);
        wait_rsp(20);
        chk("init_is_read", RSP_IS_READ, 0);
        chk("init_error", RSP_ERROR, 0);
        chk("init_rdata", RSP_RDATA, 8'h00);
        consume();
        chk("init_hi_len", last_hi_len, 3);
        chk("init_busy_done", BUSY, 0);

        // Table of single transactions, each pushed into an empty FIFO
        for (int i = 0; i < 6; i++) begin
            ack_delay = vecs[i].delay; ack_data = vecs[i].dout;
            push_cmd(vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("v%0d_issue_latency", i), REQUEST_C2, 1);
            chk($sformatf("v%0d_addr", i), ADDR_C2, vecs[i].addr);
            chk($sformatf("v%0d_rnw", i), RD_NOT_WRITE_C2, vecs[i].rd);
            chk($sformatf("v%0d_datain", i), DATAIN_C2, vecs[i].rd ? 8'h00 : vecs[i].wdata);
            wait_rsp(100);
            chk($sformatf("v%0d_is_read", i), RSP_IS_READ, vecs[i].exp_is_read);
            chk($sformatf("v%0d_rdata", i), RSP_RDATA, vecs[i].exp_rdata);
            chk($sformatf("v%0d_error", i), RSP_ERROR, vecs[i].exp_err);
            consume();
            chk($sformatf("v%0d_hi_len", i), last_hi_len, vecs[i].exp_hi);
        end

        // Response stall with a second command queued behind it
        ack_delay = 2; ack_data = 8'h5A;
        push_cmd(1'b1, 4'h9, 8'h00);
        wait_rsp(20);
        push_cmd(1'b0, 4'h2, 8'h44);
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (!RSP_VALID || RSP_RDATA != 8'h5A || REQUEST_C2) bad = 1'b1;
        end
        chk("stall_hold", bad, 0);
        chk("stall_rdata", RSP_RDATA, 8'h5A);
        consume();
        wait_req(10);
        chk("stall_next_addr", ADDR_C2, 4'h2);
        chk("stall_next_datain", DATAIN_C2, 8'h44);
        wait_rsp(20);
        chk("stall_next_is_read", RSP_IS_READ, 0);
        consume();

        // Backpressure: fill the FIFO while held in WAIT_INIT, then drain in order
        ack_delay = 4; ack_data = 8'hC4;
        RST_DONE = 1'b0;
        tick();
        issued_q.delete();
        for (int i = 0; i < 4; i++)
            push_cmd(exp_order[i].rd_not_write, exp_order[i].addr, exp_order[i].wdata);
        chk("bp_full_ready", CMD_READY, 0);
        CMD_VALID = 1'b1; CMD_RD_NOT_WRITE = exp_order[4].rd_not_write;
        CMD_ADDR = exp_order[4].addr; CMD_WDATA = exp_order[4].wdata;
        bad = 1'b0;
        repeat (3) begin tick(); if (CMD_READY || REQUEST_C2) bad = 1'b1; end
        chk("bp_ready_held_low", bad, 0);
        RST_DONE = 1'b1;
        t = 0;
        while (!CMD_READY && t < 20) begin tick(); t++; end
        chk("bp_ready_rises", CMD_READY, 1);
        tick();
        CMD_VALID = 1'b0;
        RSP_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40);
            chk($sformatf("bp%0d_is_read", i), RSP_IS_READ, exp_order[i].rd_not_write);
            chk($sformatf("bp%0d_rdata", i), RSP_RDATA, exp_order[i].rd_not_write ? 8'hC4 : 8'h00);
            tick();
        end
        RSP_READY = 1'b0;
        chk("bp_issue_count", issued_q.size(), 5);
        for (int i = 0; i < 5 && i < issued_q.size(); i++)
            chk($sformatf("bp%0d_order", i), issued_q[i], exp_order[i]);

        // Reset while a request is outstanding with two commands queued
        ack_delay = -1;
        push_cmd(1'b1, 4'h5, 8'h00);
        push_cmd(1'b0, 4'h6, 8'h66);
        push_cmd(1'b1, 4'h7, 8'h00);
        chk("mid_req_high", REQUEST_C2, 1);
        RST_N = 1'b0; RST_DONE = 1'b0;
        tick();
        chk("mid_rst_request", REQUEST_C2, 0);
        chk("mid_rst_rsp_valid", RSP_VALID, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_ready", CMD_READY, 0);
        RST_N = 1'b1;
        tick();
        chk("mid_ready_back", CMD_READY, 1);
        bad = 1'b0;
        repeat (5) begin tick(); if (REQUEST_C2 || BUSY) bad = 1'b1; end
        RST_DONE = 1'b1;
        repeat (3) begin tick(); if (REQUEST_C2 || BUSY) bad = 1'b1; end
        chk("mid_flushed_quiet", bad, 0);
        ack_delay = 2; ack_data = 8'h3E;
        push_cmd(1'b1, 4'hB, 8'h00);
        tick();
        chk("post_rst_issue", REQUEST_C2, 1);
        chk("post_rst_addr", ADDR_C2, 4'hB);
        wait_rsp(20);
        chk("post_rst_rdata", RSP_RDATA, 8'h3E);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_c2_requester.md
Name: ram_c2_requester

Overview:
Upstream master for client 2 of the RAM arbiter. It buffers read/write commands in a small FIFO and converts each one into a REQUEST_C2 / ACK_C2 transaction on the arbiter's client-2 port. It waits for arbiter initialisation (RST_DONE) before issuing anything. It returns one response per command (read data or write completion) on a valid/ready channel, and bounds every transaction with a timeout.

Parameters:
ADDR_W, 4, RAM address width (16 locations)
DATA_W, 8, RAM data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 64, max cycles REQUEST_C2 is held waiting for ACK_C2

Ports:
CLOCK  in  1  single clock, rising edge
RST_N  in  1  reset; synchronous, active-low
RST_DONE  in  1  arbiter initialisation complete
CMD_VALID  in  1  command offered
CMD_READY  out  1  FIFO can accept
CMD_RD_NOT_WRITE  in  1  1=read, 0=write
CMD_ADDR  in  ADDR_W  command address
CMD_WDATA  in  DATA_W  write data (ignored for reads)
RSP_VALID  out  1  response available
RSP_READY  in  1  response consumed
RSP_IS_READ  out  1  response belongs to a read
RSP_RDATA  out  DATA_W  read data; 0 for writes/errors
RSP_ERROR  out  1  transaction timed out
REQUEST_C2  out  1  to arbiter
RD_NOT_WRITE_C2  out  1  to arbiter
ADDR_C2  out  ADDR_W  to arbiter
DATAIN_C2  out  DATA_W  to arbiter write data
DATAOUT_C2  in  DATA_W  arbiter read data, valid when ACK_C2=1
ACK_C2  in  1  arbiter grant/complete
BUSY  out  1  FIFO non-empty or FSM not IDLE/WAIT_INIT

Behaviour:
- Reset (RST_N=0 sampled at edge) has the following effect:
  - All outputs go to 0, including CMD_READY.
  - The FIFO is flushed, the timer is cleared, and state becomes WAIT_INIT.
  - Reset mid-transaction drops REQUEST_C2 at that edge and discards any pending response.
- CMD_READY is registered and equals !full from the first non-reset edge onward.
- Push occurs when CMD_VALID & CMD_READY; push is allowed in any state, including WAIT_INIT.
- Simultaneous push and pop leave the count unchanged. A pop on full frees a slot, and READY rises the next cycle.
- Commands issue in strict FIFO order.
- All arbiter-side outputs are registered. ADDR_C2, RD_NOT_WRITE_C2 and DATAIN_C2 change only at the edge leaving IDLE, and stay stable while REQUEST_C2=1. DATAIN_C2=0 for reads.
- FSM states:
  - WAIT_INIT: REQUEST_C2=0. When RST_DONE=1 is sampled, go to IDLE.
  - IDLE:
    - If RST_DONE=0, return to WAIT_INIT.
    - Else if the FIFO is non-empty, pop the head, load the arbiter outputs, set REQUEST_C2=1, clear the timer, and go to REQ.
    - Latency: a command pushed into an empty FIFO at edge N (post-init) gives REQUEST_C2=1 after edge N+1.
  - REQ: hold the request while the timer increments.
    - If ACK_C2=1 is sampled:
      - REQUEST_C2 goes to 0.
      - RSP_RDATA captures DATAOUT_C2 (reads) or 0 (writes).
      - RSP_IS_READ is set from the command and RSP_ERROR=0.
      - RSP_VALID goes to 1, and the FSM moves to RSP.
    - Timeout: if timer == TIMEOUT_CYCLES-1 with no ACK, then:
      - REQUEST_C2 goes to 0, RSP_ERROR=1, RSP_RDATA=0, RSP_VALID=1, and the FSM moves to RSP.
      - REQUEST_C2 is therefore high exactly TIMEOUT_CYCLES cycles.
    - An ACK on the same edge as timeout wins (normal completion).
  - RSP: hold all RSP_* outputs until RSP_VALID & RSP_READY, then set RSP_VALID=0 and go to IDLE.
- The FSM guarantees REQUEST_C2 is low for at least 2 cycles between transactions.
- ACK_C2 outside REQ is ignored. RST_DONE dropping during REQ or RSP is ignored; the timeout covers it.
- The timer is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W/DATA_W constants.
  - Command struct {rd_not_write, addr, wdata}.
  - FSM state enum {WAIT_INIT, IDLE, REQ, RSP}.
- Sub-module c2_cmd_fifo: synchronous FIFO with params WIDTH and DEPTH; ports push/pop/full/empty/count.

Test Plan:
- Init gating: RST_N=0 for 2 cycles; push write addr 0xE data 0xE3 at cycle 3; RST_DONE rises at cycle 10 -> REQUEST_C2=0 until cycle 10, then 1 with ADDR_C2=0xE, DATAIN_C2=0xE3, RD_NOT_WRITE_C2=0; ACK 3 cycles later -> RSP_VALID=1, IS_READ=0, ERROR=0, RDATA=0x00.
- Read: push read 0x6; model ACKs with DATAOUT_C2=0x9D -> RSP_RDATA=0x9D, IS_READ=1; DATAIN_C2=0 throughout.
- Backpressure/order: push 5 commands (W 0xA/0xA1, R 0xA, W 0x1/0x23, R 0x1, R 0xF) with ACK delayed 4 cycles -> CMD_READY low on the 5th until the first pop; issue order matches push order; REQUEST_C2 low >=2 cycles between requests.
- Timeout: model never ACKs a read of 0x3 -> REQUEST_C2 high exactly 64 cycles; RSP_ERROR=1, RSP_RDATA=0x00; next queued command issues normally.
- Response stall: RSP_READY=0 for 10 cycles after read data 0x5A -> RSP_VALID/RSP_RDATA held at 1/0x5A; no new REQUEST_C2; resumes after the handshake.
- Reset mid-REQ: assert RST_N=0 while REQUEST_C2=1 with 2 queued -> REQUEST_C2=0, RSP_VALID=0, BUSY=0, CMD_READY=0 after that edge; after release, nothing issues until RST_DONE=1.
